// File: rtl/pipe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_pkg
// Constants and types shared by the pipeline stage register and its helper
// counter.
//   pipe_state_e  : stage state encoding (1 bit). PIPE_RUN is the reset state.
//   INST_NOP      : payload that decodes as a no-op. It is the reset/flush value.
//   PERF_CNT_MAX  : saturation ceiling of the performance counters.
//   PERF_CNT_W    : width of the performance counters.
// -----------------------------------------------------------------------------
package pipe_stage_reg_pkg;

    typedef enum logic [0:0] {
        PIPE_RUN    = 1'b0,
        PIPE_HALTED = 1'b1
    } pipe_state_e;

    localparam int unsigned PERF_CNT_W   = 32;
    localparam logic [63:0] INST_NOP     = 64'h0000_0000_0000_0000;
    localparam logic [31:0] PERF_CNT_MAX = 32'hFFFF_FFFF;

    // Next value of a saturating counter: it stops at the ceiling instead of
    // wrapping to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        logic [31:0] next_v;
        if (value == PERF_CNT_MAX) begin
            next_v = PERF_CNT_MAX;
        end else begin
            next_v = value + 32'd1;
        end
        return next_v;
    endfunction

endpackage : pipe_stage_reg_pkg

// File: rtl/pipe_stage_reg_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// 32-bit up counter that saturates at PERF_CNT_MAX and never wraps.
// Ports:
//   clk    : clock, rising edge
//   clr_n  : synchronous active-low clear (counter returns to 0)
//   en     : count enable; adds one on this edge unless already saturated
//   count  : registered counter value
// -----------------------------------------------------------------------------
module sat_counter
    import pipe_stage_reg_pkg::*;
(
    input  logic        clk,
    input  logic        clr_n,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] count_r;

    // Counter register: clear wins, otherwise increment with saturation.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_r <= 32'h0000_0000;
        end else if (en) begin
            count_r <= sat_inc(count_r);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule : sat_counter

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Pipeline stage register placed at each stage boundary (IF/ID, ID/EXE,
// EXE/MEM, MEM/WB). It carries the payload downstream, obeys the hold
// (nWrite) and bubble (flush) requests of the hazard control unit, and freezes
// the stage once a valid halt word has been captured.
//
// Optional build macro: PIPE_PERF_CNT_EN
//   When defined, the stall_cnt / flush_cnt ports and their saturating
//   counters exist. When undefined, both are absent and behaviour is otherwise
//   identical.
//
// Parameters:
//   DATA_W      : payload width in bits
//   RESET_DATA  : payload loaded on reset and on flush (default decodes as NOP)
// Ports:
//   clk         : clock, all updates on the rising edge
//   rst_n       : synchronous active-low reset
//   d_in        : payload from the upstream stage
//   valid_in    : upstream payload is a real instruction
//   halt_in     : upstream payload is the halt instruction
//   nWrite      : hold request, keep current contents
//   flush       : bubble request, load RESET_DATA
//   q_out       : registered payload to the downstream stage
//   valid_out   : q_out is a real instruction
//   bubble_out  : q_out was inserted by a flush
//   halt_out    : stage is HALTED (sticky until reset)
//   stall_cnt   : saturating hold-cycle count (PIPE_PERF_CNT_EN only)
//   flush_cnt   : saturating flush-cycle count (PIPE_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned        DATA_W     = 64,
    parameter logic [DATA_W-1:0]  RESET_DATA = DATA_W'(INST_NOP)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d_in,
    input  logic              valid_in,
    input  logic              halt_in,
    input  logic              nWrite,
    input  logic              flush,
    output logic [DATA_W-1:0] q_out,
    output logic              valid_out,
    output logic              bubble_out,
    output logic              halt_out
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    pipe_state_e       state_r;
    logic [DATA_W-1:0] q_r;
    logic              valid_r;
    logic              bubble_r;
    logic              halt_r;

    // Stage state machine and payload registers. Priority: reset, HALTED
    // freeze, flush, hold, load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= PIPE_RUN;
            q_r      <= RESET_DATA;
            valid_r  <= 1'b0;
            bubble_r <= 1'b0;
            halt_r   <= 1'b0;
        end else begin
            case (state_r)
                PIPE_HALTED: begin
                    // Frozen: only reset leaves this state.
                    state_r  <= PIPE_HALTED;
                    q_r      <= q_r;
                    valid_r  <= valid_r;
                    bubble_r <= bubble_r;
                    halt_r   <= 1'b1;
                end
                PIPE_RUN: begin
                    if (flush) begin
                        // Bubble insertion beats a simultaneous hold and
                        // discards any halt marker on the incoming word.
                        state_r  <= PIPE_RUN;
                        q_r      <= RESET_DATA;
                        valid_r  <= 1'b0;
                        bubble_r <= 1'b1;
                        halt_r   <= 1'b0;
                    end else if (nWrite) begin
                        state_r  <= PIPE_RUN;
                        q_r      <= q_r;
                        valid_r  <= valid_r;
                        bubble_r <= bubble_r;
                        halt_r   <= halt_r;
                    end else begin
                        q_r      <= d_in;
                        valid_r  <= valid_in;
                        bubble_r <= 1'b0;
                        // A halt marker on an invalid word is ignored.
                        if (halt_in && valid_in) begin
                            state_r <= PIPE_HALTED;
                            halt_r  <= 1'b1;
                        end else begin
                            state_r <= PIPE_RUN;
                            halt_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to the safe reset image.
                    state_r  <= PIPE_RUN;
                    q_r      <= RESET_DATA;
                    valid_r  <= 1'b0;
                    bubble_r <= 1'b0;
                    halt_r   <= 1'b0;
                end
            endcase
        end
    end

    assign q_out      = q_r;
    assign valid_out  = valid_r;
    assign bubble_out = bubble_r;
    assign halt_out   = halt_r;

`ifdef PIPE_PERF_CNT_EN
    logic stall_en_s;
    logic flush_en_s;

    // Counter enables: only count while running; a flush never counts as a
    // stall even when nWrite is also raised.
    always_comb begin
        stall_en_s = 1'b0;
        flush_en_s = 1'b0;
        if (state_r == PIPE_RUN) begin
            stall_en_s = nWrite & ~flush;
            flush_en_s = flush;
        end else begin
            stall_en_s = 1'b0;
            flush_en_s = 1'b0;
        end
    end

    sat_counter u_stall_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (stall_en_s),
        .count (stall_cnt)
    );

    sat_counter u_flush_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (flush_en_s),
        .count (flush_cnt)
    );
`endif

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg (DATA_W = 64, RESET_DATA = 0). Each step
// drives one edge's inputs, pushes the expected outputs to a scoreboard queue
// and pops/compares them once the edge has produced the registered result.
// Counter expectations are checked only when PIPE_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    typedef struct {
        string       tag;
        logic [63:0] q;
        logic        v;
        logic        b;
        logic        h;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] d_in;
    logic        valid_in;
    logic        halt_in;
    logic        nWrite;
    logic        flush;
    logic [63:0] q_out;
    logic        valid_out;
    logic        bubble_out;
    logic        halt_out;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    exp_t sb_q[$];
    int   n_assert;
    int   n_fail;

    pipe_stage_reg #(.DATA_W(64), .RESET_DATA(64'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_in       (d_in),
        .valid_in   (valid_in),
        .halt_in    (halt_in),
        .nWrite     (nWrite),
        .flush      (flush),
        .q_out      (q_out),
        .valid_out  (valid_out),
        .bubble_out (bubble_out),
        .halt_out   (halt_out)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field,
                       input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    // One edge: drive, push expectation, clock, pop and compare.
    task automatic step(input string tag, input logic rn, input logic [63:0] d,
                        input logic v, input logic h, input logic nw, input logic fl,
                        input logic [63:0] eq, input logic ev, input logic eb,
                        input logic eh, input logic [31:0] esc, input logic [31:0] efc);
        exp_t e;
        rst_n    = rn;
        d_in     = d;
        valid_in = v;
        halt_in  = h;
        nWrite   = nw;
        flush    = fl;
        e.tag = tag; e.q = eq; e.v = ev; e.b = eb; e.h = eh; e.sc = esc; e.fc = efc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, "q_out", q_out, e.q);
            chk(e.tag, "valid_out", {63'h0, valid_out}, {63'h0, e.v});
            chk(e.tag, "bubble_out", {63'h0, bubble_out}, {63'h0, e.b});
            chk(e.tag, "halt_out", {63'h0, halt_out}, {63'h0, e.h});
`ifdef PIPE_PERF_CNT_EN
            chk(e.tag, "stall_cnt", {32'h0, stall_cnt}, {32'h0, e.sc});
            chk(e.tag, "flush_cnt", {32'h0, flush_cnt}, {32'h0, e.fc});
`endif
        end
    endtask

    localparam logic [63:0] A = 64'h0000_0004_2001_0005;
    localparam logic [63:0] C = 64'h1111_2222_3333_4444;
    localparam logic [63:0] E = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] F = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] H = 64'hFFFF_0000_FFFF_0000;
    localparam logic [63:0] G = 64'hCAFE_F00D_1234_5678;
    localparam logic [63:0] J = 64'h5555_AAAA_5555_AAAA;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0; d_in = 64'h0; valid_in = 1'b0; halt_in = 1'b0;
        nWrite = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;

        //   tag        rn    d_in            v     h     nw    fl    q     v     b     h     stall  flush
        step("reset",   1'b0, A,              1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step("load_a",  1'b1, A,              1'b1, 1'b0, 1'b0, 1'b0, A,    1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        step("hold1",   1'b1, 64'h1,          1'b1, 1'b0, 1'b1, 1'b0, A,    1'b1, 1'b0, 1'b0, 32'd1, 32'd0);
        step("hold2",   1'b1, 64'h2,          1'b0, 1'b0, 1'b1, 1'b0, A,    1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
        step("hold3",   1'b1, 64'h3,          1'b1, 1'b1, 1'b1, 1'b0, A,    1'b1, 1'b0, 1'b0, 32'd3, 32'd0);
        step("load_c",  1'b1, C,              1'b1, 1'b0, 1'b0, 1'b0, C,    1'b1, 1'b0, 1'b0, 32'd3, 32'd0);
        step("flush_nw",1'b1, 64'h77,         1'b1, 1'b1, 1'b1, 1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 32'd3, 32'd1);
        step("hold_bub",1'b1, 64'h88,         1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 32'd4, 32'd1);
        step("inv_halt",1'b1, E,              1'b0, 1'b1, 1'b0, 1'b0, E,    1'b0, 1'b0, 1'b0, 32'd4, 32'd1);
        step("load_f",  1'b1, F,              1'b1, 1'b0, 1'b0, 1'b0, F,    1'b1, 1'b0, 1'b0, 32'd4, 32'd1);
        step("halt",    1'b1, H,              1'b1, 1'b1, 1'b0, 1'b0, H,    1'b1, 1'b0, 1'b1, 32'd4, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step("frozen_fl", 1'b1, 64'(i + 100), 1'b1, 1'b0, 1'b0, 1'b1, H, 1'b1, 1'b0, 1'b1, 32'd4, 32'd1);
        end
        step("frozen_nw",1'b1, G,             1'b0, 1'b0, 1'b1, 1'b0, H,    1'b1, 1'b0, 1'b1, 32'd4, 32'd1);
        step("frozen_ld",1'b1, G,             1'b1, 1'b0, 1'b0, 1'b0, H,    1'b1, 1'b0, 1'b1, 32'd4, 32'd1);
        step("rst_halt",1'b0, G,              1'b1, 1'b1, 1'b1, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step("load_g",  1'b1, G,              1'b1, 1'b0, 1'b0, 1'b0, G,    1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        step("fl_halt", 1'b1, H,              1'b1, 1'b1, 1'b0, 1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd1);
        step("load_j",  1'b1, J,              1'b1, 1'b0, 1'b0, 1'b0, J,    1'b1, 1'b0, 1'b0, 32'd0, 32'd1);
        step("hold_j",  1'b1, A,              1'b1, 1'b0, 1'b1, 1'b0, J,    1'b1, 1'b0, 1'b0, 32'd1, 32'd1);
        step("rst_hold",1'b0, A,              1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step("load_a2", 1'b1, A,              1'b1, 1'b0, 1'b0, 1'b0, A,    1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

`ifdef PIPE_PERF_CNT_EN
        // Preload the stall counter close to its ceiling, then hold.
        force dut.u_stall_cnt.count_r = 32'hFFFF_FFFD;
        #1;
        release dut.u_stall_cnt.count_r;
        step("sat1",    1'b1, C,              1'b1, 1'b0, 1'b1, 1'b0, A,    1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd0);
        step("sat2",    1'b1, C,              1'b1, 1'b0, 1'b1, 1'b0, A,    1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0);
        step("sat3",    1'b1, C,              1'b1, 1'b0, 1'b1, 1'b0, A,    1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Watchdog: the directed sequence is short; stop if time runs away.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pipe_stage_reg
